// File: rtl/rca_pkg.sv
// Shared definitions for the bit-serial adder controller: FSM encodings and
// the default operand width.
package rca_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 8;

endpackage

// File: rtl/serial_add_ctrl_full_adder.sv
// Single-bit full adder cell; the only arithmetic in the serial adder.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one full_adder cell processes one bit per
// clock, LSB first, behind a valid/ready handshake on each side.
module serial_add_ctrl
  import rca_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t             state;
  logic [WIDTH-1:0]   a_sr;
  logic [WIDTH-1:0]   b_sr;
  logic [WIDTH-1:0]   sum_sr;
  logic               c_reg;
  logic [CNT_W-1:0]   bit_cnt;
  logic               fa_s;
  logic               fa_co;

  full_adder u_fa (
    .a  (a_sr[0]),
    .b  (b_sr[0]),
    .ci (c_reg),
    .s  (fa_s),
    .co (fa_co)
  );

  assign sum = sum_sr;

  // c_reg holds the carry into the current bit, so on the MSB step it is the
  // carry into the MSB and XOR with the carry out gives signed overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      a_sr      <= '0;
      b_sr      <= '0;
      sum_sr    <= '0;
      c_reg     <= 1'b0;
      bit_cnt   <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid && in_ready) begin
            a_sr     <= a;
            b_sr     <= b;
            c_reg    <= cin;
            bit_cnt  <= '0;
            sum_sr   <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= ST_RUN;
          end
        end
        ST_RUN: begin
          sum_sr  <= {fa_s, sum_sr[WIDTH-1:1]};
          a_sr    <= a_sr >> 1;
          b_sr    <= b_sr >> 1;
          c_reg   <= fa_co;
          bit_cnt <= bit_cnt + CNT_W'(1);
          if (bit_cnt == LAST_BIT) begin
            cout      <= fa_co;
            ovf       <= c_reg ^ fa_co;
            out_valid <= 1'b1;
            state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed and randomized checks of serial_add_ctrl against hand-computed
// results and an arithmetic reference.
module tb_serial_add_ctrl;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  logic         busy;

  int total = 0;
  int bad   = 0;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one operand set from IDLE and let it be accepted on one edge.
  task automatic start_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv);
    a        = av;
    b        = bv;
    cin      = cv;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  // Count edges until out_valid, relative to the accepting edge.
  task automatic wait_valid(output int lat);
    lat = 1;
    tick();
    while (!out_valid && lat < W + 4) begin
      tick();
      lat++;
    end
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    logic [5:0] got;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    got = {in_ready, out_valid, busy, cout, ovf, (sum != 0)};
    total++;
    if (got !== 6'b100000) begin
      bad++;
      $display("[TB] FAIL reset_flags: got %b want 100000", got);
    end
    total++;
    if (sum !== 8'h00) begin
      bad++;
      $display("[TB] FAIL reset_sum: got %h want 00", sum);
    end
  endtask

  task automatic test_carry_ripple();
    int lat;
    start_op(8'hFF, 8'h01, 1'b0);
    total++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      bad++;
      $display("[TB] FAIL ripple_run_flags: got busy=%b in_ready=%b want 1 0", busy, in_ready);
    end
    wait_valid(lat);
    total++;
    if (lat != W) begin
      bad++;
      $display("[TB] FAIL ripple_latency: got %0d want %0d", lat, W);
    end
    total++;
    if ({sum, cout, ovf} !== {8'h00, 1'b1, 1'b0}) begin
      bad++;
      $display("[TB] FAIL ripple_result: got sum=%h cout=%b ovf=%b want 00 1 0", sum, cout, ovf);
    end
    release_result();
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("[TB] FAIL ripple_release: got out_valid=%b in_ready=%b busy=%b want 0 1 0",
               out_valid, in_ready, busy);
    end
  endtask

  task automatic test_overflow();
    int lat;
    start_op(8'h7F, 8'h01, 1'b0);
    wait_valid(lat);
    total++;
    if (out_valid !== 1'b1 || {sum, cout, ovf} !== {8'h80, 1'b0, 1'b1}) begin
      bad++;
      $display("[TB] FAIL ovf_pos: got v=%b sum=%h cout=%b ovf=%b want 1 80 0 1",
               out_valid, sum, cout, ovf);
    end
    release_result();
    start_op(8'h80, 8'h80, 1'b1);
    wait_valid(lat);
    total++;
    if (out_valid !== 1'b1 || {sum, cout, ovf} !== {8'h01, 1'b1, 1'b1}) begin
      bad++;
      $display("[TB] FAIL ovf_neg: got v=%b sum=%h cout=%b ovf=%b want 1 01 1 1",
               out_valid, sum, cout, ovf);
    end
    release_result();
  endtask

  task automatic test_backpressure();
    int lat;
    int seen;
    start_op(8'h60, 8'h30, 1'b0);
    wait_valid(lat);
    a        = 8'hAA;
    b        = 8'h11;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      total++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || {sum, cout, ovf} !== {8'h90, 1'b0, 1'b1}) begin
        bad++;
        $display("[TB] FAIL bp_hold_%0d: got v=%b rdy=%b sum=%h cout=%b ovf=%b want 1 0 90 0 1",
                 i, out_valid, in_ready, sum, cout, ovf);
      end
      tick();
    end
    in_valid = 1'b0;
    release_result();
    seen = 0;
    for (int i = 0; i < W + 2; i++) begin
      if (out_valid || busy) seen++;
      tick();
    end
    total++;
    if (seen != 0) begin
      bad++;
      $display("[TB] FAIL bp_no_accept: got %0d active cycles want 0", seen);
    end
  endtask

  task automatic test_ignore_in_run();
    int lat;
    int seen;
    start_op(8'h12, 8'h34, 1'b0);
    tick();
    tick();
    a        = 8'h55;
    b        = 8'h55;
    cin      = 1'b1;
    in_valid = 1'b1;
    tick();
    tick();
    in_valid = 1'b0;
    lat = 4;
    while (!out_valid && lat < W + 4) begin
      tick();
      lat++;
    end
    total++;
    if (lat != W) begin
      bad++;
      $display("[TB] FAIL ignore_latency: got %0d want %0d", lat, W);
    end
    total++;
    if ({sum, cout, ovf} !== {8'h46, 1'b0, 1'b0}) begin
      bad++;
      $display("[TB] FAIL ignore_result: got sum=%h cout=%b ovf=%b want 46 0 0", sum, cout, ovf);
    end
    release_result();
    seen = 0;
    for (int i = 0; i < W + 2; i++) begin
      if (out_valid || !in_ready) seen++;
      tick();
    end
    total++;
    if (seen != 0) begin
      bad++;
      $display("[TB] FAIL ignore_not_consumed: got %0d active cycles want 0", seen);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    int seen;
    start_op(8'hFF, 8'hFF, 1'b1);
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || sum !== 8'h00) begin
      bad++;
      $display("[TB] FAIL rstmid_state: got rdy=%b v=%b busy=%b sum=%h want 1 0 0 00",
               in_ready, out_valid, busy, sum);
    end
    seen = 0;
    for (int i = 0; i < W + 4; i++) begin
      if (out_valid) seen++;
      tick();
    end
    total++;
    if (seen != 0) begin
      bad++;
      $display("[TB] FAIL rstmid_no_result: got %0d valid cycles want 0", seen);
    end
    start_op(8'h0A, 8'h05, 1'b0);
    wait_valid(lat);
    total++;
    if (lat != W || {sum, cout, ovf} !== {8'h0F, 1'b0, 1'b0}) begin
      bad++;
      $display("[TB] FAIL rstmid_after: got lat=%0d sum=%h cout=%b ovf=%b want %0d 0f 0 0",
               lat, sum, cout, ovf, W);
    end
    release_result();
  endtask

  // Operands are re-offered immediately on return to IDLE, and garbage is kept
  // on the input bus with in_valid high during RUN/DONE.
  task automatic test_back_to_back();
    int           lat;
    int           results;
    logic [W-1:0] av;
    logic [W-1:0] bv;
    logic         cv;
    logic [W:0]   exact;
    logic         exp_ovf;
    results = 0;
    for (int n = 0; n < 1000; n++) begin
      av = W'($urandom);
      bv = W'($urandom);
      cv = 1'($urandom);
      exact   = {1'b0, av} + {1'b0, bv} + {{W{1'b0}}, cv};
      exp_ovf = (av[W-1] == bv[W-1]) && (exact[W-1] != av[W-1]);
      total++;
      if (in_ready !== 1'b1) begin
        bad++;
        $display("[TB] FAIL b2b_ready_%0d: got %b want 1", n, in_ready);
      end
      a        = av;
      b        = bv;
      cin      = cv;
      in_valid = 1'b1;
      tick();
      a   = W'($urandom);
      b   = W'($urandom);
      cin = 1'($urandom);
      wait_valid(lat);
      total++;
      if (lat != W) begin
        bad++;
        $display("[TB] FAIL b2b_latency_%0d: got %0d want %0d", n, lat, W);
      end
      if (out_valid) results++;
      total++;
      if ({cout, sum, ovf} !== {exact, exp_ovf}) begin
        bad++;
        $display("[TB] FAIL b2b_result_%0d: %h+%h+%b got sum=%h cout=%b ovf=%b want %h %b %b",
                 n, av, bv, cv, sum, cout, ovf, exact[W-1:0], exact[W], exp_ovf);
      end
      for (int d = int'($urandom_range(0, 2)); d > 0; d--) tick();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      total++;
      if (out_valid !== 1'b0) begin
        bad++;
        $display("[TB] FAIL b2b_dup_%0d: got out_valid=%b want 0", n, out_valid);
      end
    end
    in_valid = 1'b0;
    total++;
    if (results != 1000) begin
      bad++;
      $display("[TB] FAIL b2b_count: got %0d want 1000", results);
    end
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    test_reset();
    test_carry_ripple();
    test_overflow();
    test_backpressure();
    test_ignore_in_run();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
